mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencing controller and two-port arbiter in front of the byte-cell `generic_mem`. Shares the single memory port between requester 0 (instruction fetch) and requester 1 (load/store) with round-robin arbitration. Splits each 1-, 2- or 4-byte access into consecutive single-cell memory cycles in little-endian order. Sits between the CPU front end / LSU and the memory instance.

## Interface
- `log2_number_of_cells`, 8, memory address width in bits
- `cell_size`, 8, bits per memory cell; fixed at 8 for this block (word = 4 cells)

Ports:
- `clk` in 1 — single clock; all logic on rising edge
- `rst` in 1 — reset, synchronous, active-high
- `rN_req` in 1 (N=0,1) — access request; held high until `rN_done`
- `rN_addr` in `log2_number_of_cells` — byte address of the lowest byte
- `rN_size` in 2 — 00=1 byte, 01=2, 10=4, 11 reserved
- `rN_we` in 1 — 1=write, 0=read
- `rN_wdata` in 32 — write data; low `size` bytes used
- `rN_gnt` out 1 — one-cycle pulse; request fields sampled this cycle
- `rN_done` out 1 — one-cycle completion pulse
- `rN_rdata` out 32 — read result, zero-extended, held until that requester's next read completes
- `rN_err` out 1 — valid with `rN_done` (see Configuration)
- `mem_addr_bus` out `log2_number_of_cells` — cell address to memory
- `mem_data_bus_in` out 8 — byte to memory
- `mem_data_bus_out` in 8 — byte from memory
- `mem_we`, `mem_re` out 1 — memory write / read strobes; never both high

## Operation
- FSM: IDLE → XFER → (read only) DRAIN → DONE → IDLE.
- IDLE: if any `req`, grant per arbitration; latch addr, size, we, wdata, requester id; byte counter k=0; pulse `gnt`.
- Arbitration: round-robin pointer, reset value 0. Both requesting → pointer's requester wins. Pointer moves to the other requester after every grant. Single requester always wins.
- XFER: one cell per cycle: `mem_addr_bus`=addr+k (mod 2^`log2_number_of_cells`, wrap-around), write: `mem_we`=1, `mem_data_bus_in`=wdata[8k+7:8k]; read: `mem_re`=1. k increments; leave after k=n-1.
- Reads: memory returns byte the cycle after `mem_re`; controller stores it in rdata[8k+7:8k]. DRAIN captures the last byte. Unused upper bytes are cleared to 0.
- DONE: pulse `done` (+`err`) for latched requester; `rdata` updated for reads only.
- `req` dropping after grant is ignored; transfer finishes and `done` still pulses.
- Outputs other than the current strobe cycle: `mem_we`=`mem_re`=0, `mem_addr_bus`/`mem_data_bus_in` hold last value.

## Timing
- Cycle 0 = IDLE cycle with `gnt`. Write of n bytes: strobes cycles 1..n, `done` cycle n+1. Read: strobes 1..n, `done` cycle n+2.
- Next grant earliest the cycle after `done` (IDLE). Back-to-back 4-byte writes: 6 cycles each.
- Reset values: all `gnt`/`done`/`err`/`mem_we`/`mem_re` 0, `rdata` 0, `mem_addr_bus` 0, `mem_data_bus_in` 0, FSM IDLE, pointer 0.
- `rst` mid-transfer: abort at next edge, no `done`; cells already written stay written.

## Configuration
- `MEM_CTRL_ALIGN_CHECK_EN` defined: size 11 or addr not a multiple of the byte count → no memory strobes; FSM IDLE → DONE; `done`=1, `err`=1 cycle 1; `rdata` unchanged.
- Not defined: `err` tied 0; size 11 treated as 4 bytes; misaligned accesses proceed byte-by-byte with address wrap.

## Test plan
- Reset, r1 writes 4 bytes 0x78945658 at 0x04 → `mem_we` cycles 1–4 with cells 0x04..0x07 = 0x58,0x56,0x94,0x78; `r1_done` cycle 5.
- r1 reads size 01 at 0x04 → `mem_re` cycles 1–2, `r1_done` cycle 4, `r1_rdata`=0x00005658.
- r0 and r1 request together from reset → r0 granted first, r1 granted cycle after r0 `done`; next simultaneous pair grants r0 again (pointer back at 0 after r1).
- r0 4-byte read at 0xFE with checks disabled → addresses 0xFE,0xFF,0x00,0x01; rdata assembled in that byte order.
- With `MEM_CTRL_ALIGN_CHECK_EN`: r0 size 10 at 0x02 → no strobes, `r0_done`=`r0_err`=1 at cycle 1; size 11 at 0x00 → same.
- `rst` asserted during cycle 2 of a 4-byte write → only 0x04 (and 0x05 if its edge preceded reset) written, no `done`, all outputs at reset values next cycle.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Round-robin two-port arbiter and little-endian byte sequencer in front of the byte-cell generic_mem.
// Optional feature macro MEM_CTRL_ALIGN_CHECK_EN: reserved sizes and misaligned accesses end in err without strobes.
module mem_access_ctrl #(
  parameter int log2_number_of_cells = 8,
  parameter int cell_size            = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            r0_req,
  input  logic [log2_number_of_cells-1:0] r0_addr,
  input  logic [1:0]                      r0_size,
  input  logic                            r0_we,
  input  logic [31:0]                     r0_wdata,
  output logic                            r0_gnt,
  output logic                            r0_done,
  output logic [31:0]                     r0_rdata,
  output logic                            r0_err,
  input  logic                            r1_req,
  input  logic [log2_number_of_cells-1:0] r1_addr,
  input  logic [1:0]                      r1_size,
  input  logic                            r1_we,
  input  logic [31:0]                     r1_wdata,
  output logic                            r1_gnt,
  output logic                            r1_done,
  output logic [31:0]                     r1_rdata,
  output logic                            r1_err,
  output logic [log2_number_of_cells-1:0] mem_addr_bus,
  output logic [cell_size-1:0]            mem_data_bus_in,
  input  logic [cell_size-1:0]            mem_data_bus_out,
  output logic                            mem_we,
  output logic                            mem_re
);
  localparam int AW = log2_number_of_cells;

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DRAIN, ST_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_ptr, r_id, r_we;
  logic [2:0]            r_k, r_n;
  logic [31:0]           r_wshift, r_rbuf, r_rdata0, r_rdata1;
  logic [AW-1:0]         r_mem_addr;
  logic [cell_size-1:0]  r_mem_wdata;

  logic                  w_any, w_sel, w_grant, w_bad, w_last, w_done;
  logic [AW-1:0]         w_addr;
  logic [1:0]            w_size;
  logic                  w_we;
  logic [31:0]           w_wdata;
  logic [2:0]            w_n;
  logic [1:0]            w_cap_idx;
  logic [31:0]           w_rbuf_nxt;

  // Request mux: the pointer only matters when both sides ask at once.
  always_comb begin
    w_any   = r0_req | r1_req;
    w_sel   = (r0_req & r1_req) ? r_ptr : r1_req;
    w_addr  = w_sel ? r1_addr  : r0_addr;
    w_size  = w_sel ? r1_size  : r0_size;
    w_we    = w_sel ? r1_we    : r0_we;
    w_wdata = w_sel ? r1_wdata : r0_wdata;
    case (w_size)
      2'b00:   w_n = 3'd1;
      2'b01:   w_n = 3'd2;
      default: w_n = 3'd4;
    endcase
  end

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  logic r_err;
  assign w_bad  = (w_size == 2'b11) ||
                  ((w_size == 2'b01) && w_addr[0]) ||
                  ((w_size == 2'b10) && (w_addr[1:0] != 2'b00));
  assign r0_err = r0_done & r_err;
  assign r1_err = r1_done & r_err;
`else
  assign w_bad  = 1'b0;
  assign r0_err = 1'b0;
  assign r1_err = 1'b0;
`endif

  // Memory answers one cycle after the strobe, so the byte arriving now belongs to index k-1.
  always_comb begin
    w_last     = (r_k == (r_n - 3'd1));
    w_cap_idx  = r_k[1:0] - 2'd1;
    w_rbuf_nxt = r_rbuf;
    w_rbuf_nxt[{w_cap_idx, 3'b000} +: 8] = mem_data_bus_out;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any && !rst) begin
          w_grant     = 1'b1;
          w_state_nxt = w_bad ? ST_DONE : ST_XFER;
        end
      end
      ST_XFER: begin
        mem_we = r_we;
        mem_re = ~r_we;
        if (w_last) w_state_nxt = r_we ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_done          = (r_state == ST_DONE);
  assign r0_gnt          = w_grant & ~w_sel;
  assign r1_gnt          = w_grant & w_sel;
  assign r0_done         = w_done & ~r_id;
  assign r1_done         = w_done & r_id;
  assign r0_rdata        = r_rdata0;
  assign r1_rdata        = r_rdata1;
  assign mem_addr_bus    = r_mem_addr;
  assign mem_data_bus_in = r_mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 1'b0;
      r_id        <= 1'b0;
      r_we        <= 1'b0;
      r_k         <= 3'd0;
      r_n         <= 3'd1;
      r_wshift    <= '0;
      r_rbuf      <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_ptr    <= ~w_sel;
        r_id     <= w_sel;
        r_we     <= w_we;
        r_n      <= w_n;
        r_k      <= 3'd0;
        r_wshift <= w_wdata;
        r_rbuf   <= '0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        r_err    <= w_bad;
`endif
        if (!w_bad) begin
          r_mem_addr <= w_addr;
          if (w_we) r_mem_wdata <= w_wdata[cell_size-1:0];
        end
      end
      if (r_state == ST_XFER) begin
        r_k <= r_k + 3'd1;
        if (!r_we && (r_k != 3'd0)) r_rbuf <= w_rbuf_nxt;
        if (!w_last) begin
          r_mem_addr <= r_mem_addr + AW'(1);
          if (r_we) begin
            r_mem_wdata <= r_wshift[2*cell_size-1:cell_size];
            r_wshift    <= r_wshift >> cell_size;
          end
        end
      end
      if (r_state == ST_DRAIN) begin
        if (r_id) r_rdata1 <= w_rbuf_nxt;
        else      r_rdata0 <= w_rbuf_nxt;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed accesses push expected grants, strobes and completions;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r1_req, r0_we, r1_we;
  logic [7:0]  r0_addr, r1_addr;
  logic [1:0]  r0_size, r1_size;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [7:0]  mem_addr_bus, mem_data_bus_in, mem_data_bus_out;
  logic        mem_we, mem_re;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_size(r0_size), .r0_we(r0_we), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_size(r1_size), .r1_we(r1_we), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_addr_bus(mem_addr_bus), .mem_data_bus_in(mem_data_bus_in),
    .mem_data_bus_out(mem_data_bus_out), .mem_we(mem_we), .mem_re(mem_re)
  );

  // generic_mem stand-in: registered read, byte returned the cycle after mem_re
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  initial mem_data_bus_out = 8'h00;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr_bus] <= mem_data_bus_in;
    if (mem_re) mem_data_bus_out <= mem[mem_addr_bus];
  end

  typedef struct { bit we; logic [7:0] addr; logic [7:0] data; } strobe_t;
  typedef struct { bit id; int gap; } gnt_t;
  typedef struct { bit id; int lat; bit err; logic [31:0] rdata; } done_t;

  strobe_t     sq[$];
  gnt_t        gq[$];
  done_t       dq[$];
  logic [31:0] model_rd [2] = '{32'h0, 32'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  int cyc = 0;
  int last_done = 0;
  int gcyc [2] = '{0, 0};

  always @(negedge clk) begin
    strobe_t s;
    gnt_t    g;
    done_t   d;
    cyc++;
    if (mem_we && mem_re) fail_now("strobe_exclusive");
    if (mem_we || mem_re) begin
      if (sq.size() == 0) fail_now("unexpected_strobe");
      else begin
        s = sq.pop_front();
        chk("strobe_we", {31'b0, mem_we}, {31'b0, s.we});
        chk("strobe_addr", {24'b0, mem_addr_bus}, {24'b0, s.addr});
        if (s.we) chk("strobe_wdata", {24'b0, mem_data_bus_in}, {24'b0, s.data});
      end
    end
    if (r0_gnt || r1_gnt) begin
      if (r0_gnt && r1_gnt) fail_now("gnt_both");
      if (gq.size() == 0) fail_now("unexpected_gnt");
      else begin
        g = gq.pop_front();
        chk("gnt_id", {31'b0, r1_gnt}, {31'b0, g.id});
        gcyc[r1_gnt] = cyc;
        if (g.gap >= 0) chk("gnt_gap_after_done", cyc - last_done, g.gap);
      end
    end
    if (r0_done || r1_done) begin
      if (r0_done && r1_done) fail_now("done_both");
      if (dq.size() == 0) fail_now("unexpected_done");
      else begin
        d = dq.pop_front();
        chk("done_id", {31'b0, r1_done}, {31'b0, d.id});
        chk("done_latency", cyc - gcyc[d.id], d.lat);
        chk("done_err", {31'b0, (d.id ? r1_err : r0_err)}, {31'b0, d.err});
        chk("done_rdata", d.id ? r1_rdata : r0_rdata, d.rdata);
      end
      last_done = cyc;
    end
  end

  // Queue the expected grant, strobe sequence and completion of one access.
  task automatic expect_acc(input bit id, input logic [7:0] a, input logic [1:0] sz, input bit we,
                            input logic [31:0] wd, input logic [31:0] rd, input bit bad, input int gap);
    int      n;
    strobe_t s;
    gnt_t    g;
    done_t   d;
    logic [7:0] ak;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    g.id = id; g.gap = gap;
    gq.push_back(g);
    if (!bad) begin
      for (int k = 0; k < n; k++) begin
        ak = a + 8'(k);
        s.we = we; s.addr = ak; s.data = wd[8*k +: 8];
        sq.push_back(s);
      end
    end
    if (!we && !bad) model_rd[id] = rd;
    d.id = id; d.err = bad; d.rdata = model_rd[id];
    d.lat = bad ? 1 : (we ? n + 1 : n + 2);
    dq.push_back(d);
  endtask

  // Called just after a rising edge; holds req until granted, then drops it.
  task automatic issue(input bit id, input logic [7:0] a, input logic [1:0] sz, input bit we,
                       input logic [31:0] wd);
    bit got;
    got = 1'b0;
    if (id) begin r1_req = 1; r1_addr = a; r1_size = sz; r1_we = we; r1_wdata = wd; end
    else    begin r0_req = 1; r0_addr = a; r0_size = sz; r0_we = we; r0_wdata = wd; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (id ? r1_gnt : r0_gnt) got = 1'b1;
    end
    if (!got) fail_now(id ? "gnt_timeout_r1" : "gnt_timeout_r0");
    @(posedge clk);
    #1;
    if (id) r1_req = 0; else r0_req = 0;
  endtask

  task automatic wait_idle();
    bit empty;
    empty = 1'b0;
    for (int i = 0; i < 60 && !empty; i++) begin
      @(negedge clk);
      empty = (sq.size() == 0) && (gq.size() == 0) && (dq.size() == 0);
    end
    if (!empty) begin
      fail_now("drain_timeout");
      sq.delete(); gq.delete(); dq.delete();
    end
  endtask

  task automatic single(input bit id, input logic [7:0] a, input logic [1:0] sz, input bit we,
                        input logic [31:0] wd, input logic [31:0] rd, input bit bad);
    expect_acc(id, a, sz, we, wd, rd, bad, -1);
    @(posedge clk); #1;
    issue(id, a, sz, we, wd);
    wait_idle();
  endtask

  task automatic check_reset_outputs();
    chk("rst_gnt",   {30'b0, r1_gnt, r0_gnt}, 32'h0);
    chk("rst_done",  {28'b0, r1_done, r0_done, r1_err, r0_err}, 32'h0);
    chk("rst_strb",  {30'b0, mem_we, mem_re}, 32'h0);
    chk("rst_addr",  {24'b0, mem_addr_bus}, 32'h0);
    chk("rst_wdata", {24'b0, mem_data_bus_in}, 32'h0);
    chk("rst_r0_rdata", r0_rdata, 32'h0);
    chk("rst_r1_rdata", r1_rdata, 32'h0);
  endtask

  initial begin
    rst = 1;
    r0_req = 0; r0_addr = 0; r0_size = 0; r0_we = 0; r0_wdata = 0;
    r1_req = 0; r1_addr = 0; r1_size = 0; r1_we = 0; r1_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_reset_outputs();

    // word write then halfword read-back
    single(1, 8'h04, 2'b10, 1, 32'h78945658, 32'h0, 0);
    single(1, 8'h04, 2'b01, 0, 32'h0, 32'h00005658, 0);

    // simultaneous pairs: pointer is at 0, r0 first, r1 granted right after r0 done
    expect_acc(0, 8'h10, 2'b00, 1, 32'h00000011, 32'h0, 0, -1);
    expect_acc(1, 8'h20, 2'b01, 1, 32'h0000BEEF, 32'h0, 0, 1);
    @(posedge clk); #1;
    fork
      issue(0, 8'h10, 2'b00, 1, 32'h00000011);
      issue(1, 8'h20, 2'b01, 1, 32'h0000BEEF);
    join
    wait_idle();
    expect_acc(0, 8'h10, 2'b00, 0, 32'h0, 32'h00000011, 0, -1);
    expect_acc(1, 8'h20, 2'b01, 0, 32'h0, 32'h0000BEEF, 0, 1);
    @(posedge clk); #1;
    fork
      issue(0, 8'h10, 2'b00, 0, 32'h0);
      issue(1, 8'h20, 2'b01, 0, 32'h0);
    join
    wait_idle();

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    single(0, 8'h04, 2'b10, 0, 32'h0, 32'h78945658, 0);
    single(0, 8'h02, 2'b10, 0, 32'h0, 32'h0, 1);
    single(0, 8'h00, 2'b11, 0, 32'h0, 32'h0, 1);
    single(1, 8'h05, 2'b01, 1, 32'h0000EEEE, 32'h0, 1);
    single(1, 8'h05, 2'b00, 0, 32'h0, 32'h00000056, 0);
`else
    // address wrap, reserved size as a word, upper-byte clearing
    single(1, 8'hFE, 2'b01, 1, 32'h0000A1B2, 32'h0, 0);
    single(1, 8'h00, 2'b01, 1, 32'h0000C3D4, 32'h0, 0);
    single(0, 8'hFE, 2'b10, 0, 32'h0, 32'hC3D4A1B2, 0);
    single(0, 8'h04, 2'b11, 0, 32'h0, 32'h78945658, 0);
    single(0, 8'h05, 2'b00, 0, 32'h0, 32'h00000056, 0);
`endif

    // reset during the second strobe cycle of an r0 word write
    begin
      strobe_t s;
      gnt_t    g;
      g.id = 0; g.gap = -1;
      gq.push_back(g);
      s.we = 1; s.addr = 8'h04; s.data = 8'h0D; sq.push_back(s);
      s.we = 1; s.addr = 8'h05; s.data = 8'hF0; sq.push_back(s);
    end
    @(posedge clk); #1;
    issue(0, 8'h04, 2'b10, 1, 32'hCAFEF00D);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check_reset_outputs();
    chk("abort_strobes_left", sq.size(), 0);
    model_rd[0] = 32'h0;
    model_rd[1] = 32'h0;
    repeat (6) @(negedge clk);

    // pointer back at 0 after reset, partial write visible in memory
    expect_acc(0, 8'h06, 2'b00, 0, 32'h0, 32'h00000094, 0, -1);
    expect_acc(1, 8'h04, 2'b10, 0, 32'h0, 32'h7894F00D, 0, 1);
    @(posedge clk); #1;
    fork
      issue(0, 8'h06, 2'b00, 0, 32'h0);
      issue(1, 8'h04, 2'b10, 0, 32'h0);
    join
    wait_idle();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end
endmodule
